onchip_mem_pipelined: RTL
=========================

Name: onchip_mem_pipelined

Overview:
Parametrised single-port on-chip RAM that acts as an Avalon-MM slave. It is the successor to the fixed 32-bit × 64K unregistered-output memory. It adds generic width and depth, a selectable pipelined read latency with readdatavalid, and a hardware clear engine that fills memory after reset or on request. It sits on the system interconnect as program/data memory for the soft processor and DMA masters.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
ADDR_WIDTH, 16, word-address width.
DEPTH, 65536, number of words; DEPTH ≤ 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values are 1 and 2.
CLEAR_ON_RESET, 1, 1 = run the clear engine automatically after reset release.
CLEAR_VALUE, 0, word value written by the clear engine.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
chipselect  input  1  slave select.
address  input  ADDR_WIDTH  word address.
byteenable  input  DATA_WIDTH/8  write byte lanes.
read  input  1  read request.
write  input  1  write request.
writedata  input  DATA_WIDTH  write data.
readdata  output  DATA_WIDTH  read data; valid when readdatavalid=1.
readdatavalid  output  1  one-cycle pulse for each accepted read.
waitrequest  output  1  slave stall; high while clearing.
clear_req  input  1  single-cycle pulse that requests a full clear.
clear_busy  output  1  high while the clear engine is active or pending.

Behaviour:
- Reset values: readdata=0, readdatavalid=0, read pipeline empty.
  - With CLEAR_ON_RESET=1: waitrequest=1, clear_busy=1, FSM=CLEAR, clear address=0.
  - With CLEAR_ON_RESET=0: waitrequest=0, clear_busy=0, FSM=IDLE.
- FSM states:
  - IDLE: serves bus traffic.
  - DRAIN: waitrequest=1; waits until the read pipeline is empty, then goes to CLEAR.
  - CLEAR: waitrequest=1; writes CLEAR_VALUE with all lanes to clear address, then increments it. Returns to IDLE the cycle after writing DEPTH-1.
- clear_busy=1 in DRAIN and CLEAR.
- Transaction acceptance: a transaction is accepted in a cycle when chipselect=1 and waitrequest=0.
- Write: accepted when write=1. Only lanes with byteenable[i]=1 are updated. Takes effect at the clock edge.
- Read: accepted when read=1 and write=0. readdatavalid=1 and readdata are presented exactly READ_LATENCY cycles later.
  - Back-to-back reads are accepted every cycle.
  - Responses come out in order; there is no backpressure on responses.
- read=1 and write=1 together: treated as a write only; no readdatavalid is generated.
- Read-during-write, same address, consecutive cycles: a read accepted the cycle after a write returns the new data.
- Reads with latency 2 see any write accepted on or before the read's acceptance cycle.
- address ≥ DEPTH:
  - Writes are dropped.
  - Reads return 0 and still pulse readdatavalid.
- clear_req:
  - In IDLE: next state is DRAIN. If the pipeline is empty, DRAIN lasts 1 cycle.
  - During DRAIN or CLEAR: ignored; no restart and no queueing.
  - A bus request in the same cycle as clear_req in IDLE is still accepted, because waitrequest is still 0 that cycle.
- Clear duration: DEPTH cycles exactly, plus the drain time.
- Reset mid-clear: on release, the clear restarts from address 0 if CLEAR_ON_RESET=1. Otherwise go to IDLE with contents undefined.
- Reset mid-read: in-flight reads are discarded and no readdatavalid is issued.
- readdata holds its last valid value between pulses.
- RAM is inferred: synchronous write, registered read (latency 1). READ_LATENCY=2 adds one output register stage.

Optional Feature:
ONCHIP_MEM_PARITY_EN
- Defined:
  - Each byte stores an extra even-parity bit, written on writes and on clears.
  - Adds output port parity_err (1 bit), which pulses high together with readdatavalid when any byte read back has wrong parity.
  - Adds output port parity_err_addr (ADDR_WIDTH bits), which latches the address of the first error and holds it until the next clear completes.
  - Both outputs reset to 0.
  - Reads of address ≥ DEPTH never flag an error.
- Undefined: no parity storage and neither port exists.

Test Plan:
- Bench uses ADDR_WIDTH=4, DEPTH=12, CLEAR_VALUE=32'hA5A5A5A5, READ_LATENCY=1.
- Reset release: waitrequest=1 for exactly 12 cycles, clear_busy falls with it. A subsequent read of address 11 returns 32'hA5A5A5A5 with readdatavalid 1 cycle later.
- Write 32'h11223344 to address 3 with byteenable=4'b0101 over cleared memory. A read of address 3 returns 32'hA522A544.
- Back-to-back reads of addresses 0,1,2 on cycles N..N+2 after writes of 1,2,3: readdatavalid at N+1..N+3 with data 1,2,3. Repeat with READ_LATENCY=2: valid at N+2..N+4.
- clear_req with two reads in flight: both readdatavalid pulses are delivered first. waitrequest=1 from the next cycle, for drain plus 12 cycles. Afterwards all words read 32'hA5A5A5A5.
- Write 32'hFFFFFFFF to address 13 (out of range), then read address 13: readdata=0 with readdatavalid=1. Address 13 mod 12 (address 1) is unchanged.
- Assert reset_n=0 at clear address 5, release: clear restarts at 0 and waitrequest stays high for a full 12 cycles.
- With parity enabled, force a flipped bit: parity_err pulses with readdatavalid.

Source files
------------

// File: rtl/onchip_mem_pipelined.sv
// onchip_mem_pipelined: parametrised single-port Avalon-MM RAM with pipelined reads and a clear engine.
// Define ONCHIP_MEM_PARITY_EN to add per-byte even parity with parity_err / parity_err_addr outputs.
module onchip_mem_pipelined #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DEPTH          = 65536,
    parameter int                    READ_LATENCY   = 1,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chipselect,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic                    clear_req,
    output logic                    clear_busy
`ifdef ONCHIP_MEM_PARITY_EN
    ,
    output logic                    parity_err,
    output logic [ADDR_WIDTH-1:0]   parity_err_addr
`endif
);
    localparam int                    NB        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;
    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] clr_addr_reg, clr_addr_next;

    logic                  in_range, accept, wr_en, rd_accept, clearing, we_any, pipe_busy;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0]         w_be;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] stage1_data;
    logic                  rd_v1_reg, rd_oor1_reg, rd_seen_reg;

    assign waitrequest = (state_reg != ST_IDLE);
    assign clear_busy  = waitrequest;
    assign clearing    = (state_reg == ST_CLEAR);
    assign in_range    = ({1'b0, address} < DEPTH_W);
    assign accept      = chipselect & ~waitrequest;
    assign wr_en       = accept & write & in_range;
    assign rd_accept   = accept & read & ~write;

    // The clear engine and the bus share the single write port; they never overlap in time.
    assign we_any = clearing | wr_en;
    assign w_addr = clearing ? clr_addr_reg : address;
    assign w_data = clearing ? CLEAR_VALUE : writedata;
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign w_be[gi] = clearing | byteenable[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clear_req) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_reg == LAST_ADDR) begin
                    state_next    = ST_IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_addr_reg <= '0;
            rd_v1_reg    <= 1'b0;
            rd_oor1_reg  <= 1'b0;
            rd_seen_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            rd_v1_reg    <= rd_accept;
            if (rd_accept) begin
                rd_oor1_reg <= ~in_range;
                rd_seen_reg <= 1'b1;
            end
        end
    end

    // Storage and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (we_any) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) mem[w_addr][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
        if (rd_accept) ram_q <= mem[address];
    end

    // rd_seen_reg keeps readdata at 0 after reset until the first read completes.
    assign stage1_data = (rd_seen_reg && !rd_oor1_reg) ? ram_q : '0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_v2_reg;
            logic [DATA_WIDTH-1:0] rd_data2_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_v2_reg    <= 1'b0;
                    rd_data2_reg <= '0;
                end else begin
                    rd_v2_reg <= rd_v1_reg;
                    if (rd_v1_reg) rd_data2_reg <= stage1_data;
                end
            end
            assign readdatavalid = rd_v2_reg;
            assign readdata      = rd_data2_reg;
            assign pipe_busy     = rd_v1_reg;
        end else begin : g_lat1
            assign readdatavalid = rd_v1_reg;
            assign readdata      = stage1_data;
            assign pipe_busy     = 1'b0;
        end
    endgenerate

`ifdef ONCHIP_MEM_PARITY_EN
    logic [NB-1:0]         par_mem [DEPTH];
    logic [NB-1:0]         par_q, w_par, q_par;
    logic [ADDR_WIDTH-1:0] rd_addr1_reg, perr_addr_out;
    logic                  stage1_perr, perr_out, err_seen_reg, clear_done;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_par
            assign w_par[gi] = ^w_data[gi*8 +: 8];
            assign q_par[gi] = ^ram_q[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we_any) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) par_mem[w_addr][b] <= w_par[b];
            end
        end
        if (rd_accept) par_q <= par_mem[address];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_addr1_reg <= '0;
        else if (rd_accept) rd_addr1_reg <= address;
    end

    assign stage1_perr = rd_v1_reg & ~rd_oor1_reg & (par_q != q_par);
    assign clear_done  = clearing & (clr_addr_reg == LAST_ADDR);

    generate
        if (READ_LATENCY == 2) begin : g_par_lat2
            logic                  perr2_reg;
            logic [ADDR_WIDTH-1:0] addr2_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    perr2_reg <= 1'b0;
                    addr2_reg <= '0;
                end else begin
                    perr2_reg <= stage1_perr;
                    if (rd_v1_reg) addr2_reg <= rd_addr1_reg;
                end
            end
            assign perr_out      = perr2_reg;
            assign perr_addr_out = addr2_reg;
        end else begin : g_par_lat1
            assign perr_out      = stage1_perr;
            assign perr_addr_out = rd_addr1_reg;
        end
    endgenerate

    // Only the first error address is kept; a completed clear re-arms the latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_seen_reg    <= 1'b0;
            parity_err_addr <= '0;
        end else if (clear_done) begin
            err_seen_reg    <= 1'b0;
            parity_err_addr <= '0;
        end else if (perr_out && !err_seen_reg) begin
            err_seen_reg    <= 1'b1;
            parity_err_addr <= perr_addr_out;
        end
    end

    assign parity_err = perr_out;
`endif
endmodule
